// File: rtl/fifo_byte_serializer_pkg.sv
// Shared types and widths for the fifo-to-byte-stream serializer.
package fifo_byte_serializer_pkg;

    localparam int FIFO_DATA_W = 32;
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        SEND = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_byte_serializer.sv
// Pops 32-bit words from the fifo read port and streams them out as four bytes
// over a valid/ready handshake, counting completed words and read errors.
module fifo_byte_serializer
    import fifo_byte_serializer_pkg::*;
#(
    parameter int BYTE_ORDER = 0,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   fifo_empty,
    input  logic                   fifo_rd_ack,
    input  logic                   fifo_rd_err,
    input  logic [FIFO_DATA_W-1:0] fifo_d_out,
    output logic                   fifo_rd_en,
    output logic [BYTE_W-1:0]      byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   busy,
    output logic [CNT_W-1:0]       words_done,
    output logic [7:0]             rd_err_cnt
);

    // Byte stream handshake: a byte moves on every rising edge where
    // byte_valid and byte_ready are both 1; byte_valid and byte_out stay
    // stable until that happens.

    state_e                 state_q, state_d;
    logic [FIFO_DATA_W-1:0] shift_q, shift_d;
    logic [1:0]             idx_q, idx_d;
    logic                   rd_en_q, rd_en_d;
    logic [BYTE_W-1:0]      byte_out_q, byte_out_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       words_done_q, words_done_d;
    logic [7:0]             rd_err_cnt_q, rd_err_cnt_d;

    logic [FIFO_DATA_W-1:0] mux_word;
    logic [1:0]             mux_idx;
    logic [1:0]             mux_lane;
    logic [BYTE_W-1:0]      mux_byte;

    // The next byte to present: byte 0 of the word arriving from the fifo, or
    // the following byte of the held word once the current one is accepted.
    always_comb begin
        mux_word = (state_q == WAIT) ? fifo_d_out : shift_q;
        mux_idx  = (state_q == WAIT) ? 2'd0 : (idx_q + 2'd1);
        mux_lane = (BYTE_ORDER != 0) ? (2'd3 - mux_idx) : mux_idx;
        case (mux_lane)
            2'd0:    mux_byte = mux_word[7:0];
            2'd1:    mux_byte = mux_word[15:8];
            2'd2:    mux_byte = mux_word[23:16];
            default: mux_byte = mux_word[31:24];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        rd_en_d      = 1'b0;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        words_done_d = words_done_q;
        rd_err_cnt_d = rd_err_cnt_q;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = REQ;
                    rd_en_d = 1'b1;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (fifo_rd_ack) begin
                    shift_d      = fifo_d_out;
                    idx_d        = 2'd0;
                    byte_out_d   = mux_byte;
                    byte_valid_d = 1'b1;
                    state_d      = SEND;
                end else if (fifo_rd_err || !fifo_rd_ack) begin
                    // A missing acknowledge is counted the same as an explicit error.
                    if (rd_err_cnt_q != 8'hff) begin
                        rd_err_cnt_d = rd_err_cnt_q + 8'd1;
                    end
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (byte_ready) begin
                    if (idx_q == 2'd3) begin
                        byte_valid_d = 1'b0;
                        byte_out_d   = '0;
                        idx_d        = 2'd0;
                        words_done_d = words_done_q + CNT_W'(1);
                        state_d      = IDLE;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        byte_out_d = mux_byte;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            idx_q        <= '0;
            rd_en_q      <= 1'b0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            words_done_q <= '0;
            rd_err_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            rd_en_q      <= rd_en_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            words_done_q <= words_done_d;
            rd_err_cnt_q <= rd_err_cnt_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign busy       = busy_q;
    assign words_done = words_done_q;
    assign rd_err_cnt = rd_err_cnt_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Bench for fifo_byte_serializer: an LSB-first and an MSB-first instance share one fifo model.
module tb_fifo_byte_serializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fifo_empty;
    logic        fifo_rd_ack;
    logic        fifo_rd_err;
    logic [31:0] fifo_d_out;
    logic        byte_ready;

    logic        rd_en0, rd_en1;
    logic [7:0]  out0, out1;
    logic        valid0, valid1;
    logic        busy0, busy1;
    logic [15:0] wd0;
    logic [2:0]  wd1;
    logic [7:0]  err0, err1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  exp_q_lsb[$];
    logic [7:0]  exp_q_msb[$];
    logic [31:0] fifo_q[$];
    logic [31:0] pend_q[$];
    logic        force_ne = 1'b0;
    logic [15:0] exp_words = '0;
    logic [7:0]  exp_err = '0;
    int          bcount = 0;
    int          rd_pulses = 0;
    logic        prev_rd = 1'b0;

    typedef struct {
        logic [31:0] word;
        int          stall_idx;
        int          stall_len;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    fifo_byte_serializer #(.BYTE_ORDER(0), .CNT_W(16)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty),
        .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err), .fifo_d_out(fifo_d_out),
        .fifo_rd_en(rd_en0), .byte_out(out0), .byte_valid(valid0), .byte_ready(byte_ready),
        .busy(busy0), .words_done(wd0), .rd_err_cnt(err0)
    );

    fifo_byte_serializer #(.BYTE_ORDER(1), .CNT_W(3)) dut_msb (
        .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty),
        .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err), .fifo_d_out(fifo_d_out),
        .fifo_rd_en(rd_en1), .byte_out(out1), .byte_valid(valid1), .byte_ready(byte_ready),
        .busy(busy1), .words_done(wd1), .rd_err_cnt(err1)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void push_exp(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            exp_q_lsb.push_back(8'((w >> (8 * i)) & 32'hff));
            exp_q_msb.push_back(8'((w >> (8 * (3 - i))) & 32'hff));
        end
    endfunction

    // 8-deep fifo with registered read acknowledge and registered empty flag.
    always @(posedge clk) begin
        if (!reset_n) begin
            fifo_q.delete();
            fifo_rd_ack <= 1'b0;
            fifo_rd_err <= 1'b0;
            fifo_d_out  <= '0;
            fifo_empty  <= 1'b1;
        end else begin
            fifo_rd_ack <= 1'b0;
            fifo_rd_err <= 1'b0;
            if (rd_en0) begin
                if (fifo_q.size() > 0) begin
                    fifo_rd_ack <= 1'b1;
                    fifo_d_out  <= fifo_q.pop_front();
                end else begin
                    fifo_rd_err <= 1'b1;
                end
            end
            while (pend_q.size() > 0 && fifo_q.size() < 8) fifo_q.push_back(pend_q.pop_front());
            fifo_empty <= (fifo_q.size() == 0) && !force_ne;
        end
    end

    // Scoreboard: byte order, hold-while-stalled, counters.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q_lsb.delete();
            exp_q_msb.delete();
            exp_words = '0;
            exp_err   = '0;
            bcount    = 0;
            prev_rd   = 1'b0;
        end else begin
            chk("words_done", wd0, exp_words);
            chk("words_done_w3", wd1, exp_words[2:0]);
            chk("rd_err_cnt", err0, exp_err);
            chk("rd_err_cnt_msb", err1, exp_err);
            if (rd_en0) begin
                chk("rd_en_single", prev_rd, 0);
                rd_pulses++;
            end
            prev_rd = rd_en0;
            if (valid0) begin
                if (exp_q_lsb.size() == 0) chk("byte_unexpected_lsb", valid0, 0);
                else begin
                    chk("byte_lsb_first", out0, exp_q_lsb[0]);
                    if (byte_ready) begin
                        void'(exp_q_lsb.pop_front());
                        bcount++;
                        if (bcount == 4) begin
                            bcount = 0;
                            exp_words++;
                        end
                    end
                end
            end
            if (valid1) begin
                if (exp_q_msb.size() == 0) chk("byte_unexpected_msb", valid1, 0);
                else begin
                    chk("byte_msb_first", out1, exp_q_msb[0]);
                    if (byte_ready) void'(exp_q_msb.pop_front());
                end
            end
            if (fifo_rd_err) exp_err = (exp_err == 8'd255) ? 8'd255 : exp_err + 8'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_vec(input vec_t v);
        int t_empty, t_rd, t_val, k, stalled, pulses0, c;
        t_empty = -1; t_rd = -1; t_val = -1; k = 0; stalled = 0;
        pulses0 = rd_pulses;
        pend_q.push_back(v.word);
        exp_q_lsb.push_back(v.b0); exp_q_lsb.push_back(v.b1);
        exp_q_lsb.push_back(v.b2); exp_q_lsb.push_back(v.b3);
        exp_q_msb.push_back(v.b3); exp_q_msb.push_back(v.b2);
        exp_q_msb.push_back(v.b1); exp_q_msb.push_back(v.b0);
        for (c = 0; c < 60; c++) begin
            step();
            if (!fifo_empty && t_empty < 0) t_empty = c;
            if (rd_en0 && t_rd < 0) t_rd = c;
            if (valid0 && t_val < 0) t_val = c;
            if (valid0) begin
                if (k == v.stall_idx && stalled < v.stall_len) begin
                    byte_ready = 1'b0;
                    stalled++;
                end else begin
                    byte_ready = 1'b1;
                    k++;
                end
            end else begin
                byte_ready = 1'b1;
            end
            if (k == 4) break;
        end
        byte_ready = 1'b1;
        repeat (3) step();
        chk("vec_bytes_taken", k, 4);
        chk("vec_rd_en_delay", t_rd - t_empty, 1);
        chk("vec_first_valid_delay", t_val - t_empty, 3);
        chk("vec_rd_pulses", rd_pulses - pulses0, 1);
        chk("vec_busy_end", busy0, 0);
        chk("vec_bytes_left", exp_q_lsb.size(), 0);
    endtask

    task automatic drain(input bit rnd, input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            if (exp_q_lsb.size() == 0 && fifo_q.size() == 0 && pend_q.size() == 0 && !busy0) break;
            byte_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
        end
        chk("drain_in_budget", (c < budget) ? 1 : 0, 1);
        byte_ready = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        int pulses0, pushed, c;
        logic [31:0] w;
        logic [31:0] burst[8];

        vecs[0] = '{32'h1234_5678, -1, 0, 8'h78, 8'h56, 8'h34, 8'h12};
        vecs[1] = '{32'haaaa_eeee,  1, 5, 8'hee, 8'hee, 8'haa, 8'haa};
        vecs[2] = '{32'hdead_beef,  0, 2, 8'hef, 8'hbe, 8'had, 8'hde};
        vecs[3] = '{32'h0102_0304,  3, 1, 8'h04, 8'h03, 8'h02, 8'h01};
        vecs[4] = '{32'h0000_0000,  2, 3, 8'h00, 8'h00, 8'h00, 8'h00};
        burst = '{32'h0230_0000, 32'h1111_2222, 32'hdead_beef, 32'h0000_00ff,
                  32'hff00_0000, 32'h8080_0101, 32'h7e7e_a5a5, 32'h5234_2345};

        reset_n    = 1'b1;
        byte_ready = 1'b1;
        #1 reset_n = 1'b0;
        step();
        chk("reset_valid", valid0, 0);
        chk("reset_rd_en", rd_en0, 0);
        chk("reset_busy", busy0, 0);
        chk("reset_byte_out", out0, 0);
        chk("reset_words_done", wd0, 0);
        chk("reset_rd_err_cnt", err0, 0);
        chk("reset_valid_msb", valid1, 0);
        step();
        reset_n = 1'b1;
        repeat (3) step();

        for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

        pulses0 = rd_pulses;
        for (int i = 0; i < 8; i++) begin
            pend_q.push_back(burst[i]);
            push_exp(burst[i]);
        end
        drain(1'b0, 300);
        chk("burst_rd_pulses", rd_pulses - pulses0, 8);
        chk("burst_fifo_empty", fifo_q.size(), 0);

        pushed = 0;
        for (c = 0; c < 4000 && (pushed < 40 || exp_q_lsb.size() > 0); c++) begin
            if (pushed < 40 && fifo_q.size() + pend_q.size() < 8 && $urandom_range(0, 1) == 1) begin
                w = $urandom;
                pend_q.push_back(w);
                push_exp(w);
                pushed++;
            end
            byte_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("random_in_budget", (c < 4000) ? 1 : 0, 1);
        drain(1'b1, 300);

        pulses0 = rd_pulses;
        force_ne = 1'b1;
        step();
        force_ne = 1'b0;
        repeat (8) step();
        chk("err_single_cnt", err0, 1);
        chk("err_single_rd_pulses", rd_pulses - pulses0, 1);
        chk("err_single_busy", busy0, 0);
        force_ne = 1'b1;
        repeat (910) step();
        force_ne = 1'b0;
        repeat (8) step();
        chk("err_saturate", err0, 255);
        chk("err_saturate_msb", err1, 255);
        chk("err_busy_end", busy0, 0);

        pend_q.push_back(32'hcccc_cccc);
        push_exp(32'hcccc_cccc);
        byte_ready = 1'b0;
        for (c = 0; c < 20 && !valid0; c++) step();
        chk("rst_pre_valid", valid0, 1);
        byte_ready = 1'b1;
        step();
        step();
        byte_ready = 1'b0;
        chk("rst_pre_byte2_valid", valid0, 1);
        chk("rst_pre_byte2_out", out0, 8'hcc);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async_valid", valid0, 0);
        chk("rst_async_valid_msb", valid1, 0);
        chk("rst_async_rd_en", rd_en0, 0);
        chk("rst_async_busy", busy0, 0);
        chk("rst_async_words_done", wd0, 0);
        chk("rst_async_rd_err_cnt", err0, 0);
        step();
        step();
        reset_n    = 1'b1;
        byte_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("post_reset_quiet", {valid0, valid1, rd_en0, busy0}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_byte_serializer.md
Name: fifo_byte_serializer

Overview:
- Downstream consumer of the 32-bit, 8-deep fifo.
- Pops one word at a time through the fifo read port (rd_en, rd_ack, rd_err, d_out, empty).
- Emits each word as four bytes on a valid/ready byte stream that feeds the byte-wide link/UART stage.
- Also keeps a count of completed words and of read errors, for status readback.

Parameters:
BYTE_ORDER, 0, 0 = least-significant byte first, 1 = most-significant byte first
CNT_W, 16, width of the completed-word counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
fifo_empty  input  1  fifo empty flag
fifo_rd_ack  input  1  fifo read acknowledge, registered, valid the cycle after rd_en was sampled
fifo_rd_err  input  1  fifo read error (read attempted while empty), same timing as rd_ack
fifo_d_out  input  32  fifo read data, valid alongside fifo_rd_ack
fifo_rd_en  output  1  read request to fifo, registered, single-cycle pulse
byte_out  output  8  serialized byte
byte_valid  output  1  byte_out holds a valid byte
byte_ready  input  1  downstream accepts byte_out this cycle
busy  output  1  high in any state other than IDLE
words_done  output  CNT_W  count of words fully transmitted, wraps modulo 2^CNT_W
rd_err_cnt  output  8  count of read errors, saturates at 255

Behaviour:
- Reset (reset_n = 0, asynchronous): state goes to IDLE; all outputs and the internal shift register and byte index go to 0.
- Reset mid-operation discards the in-flight word; no partial bytes are emitted afterwards.

State machine:
- IDLE: if fifo_empty = 0 at the clock edge, go to REQ. Otherwise stay.
- REQ: fifo_rd_en = 1 for exactly this one cycle. Then go to WAIT unconditionally.
- WAIT: fifo_rd_en = 0. At the clock edge:
  - fifo_rd_ack = 1: load fifo_d_out into the 32-bit shift register, set byte index = 0, go to SEND.
  - fifo_rd_err = 1: increment rd_err_cnt (saturating), go to IDLE.
  - Neither asserted: treated as a read error (same handling).
- SEND: byte_valid = 1.
  - byte_out = byte[idx] of the shift register. BYTE_ORDER 0 gives idx 0..3 = bits [7:0], [15:8], [23:16], [31:24]. BYTE_ORDER 1 reverses this order.
  - On an edge with byte_valid & byte_ready: idx increments.
  - On the transfer of idx 3: byte_valid drops, words_done increments, go to IDLE.
  - While byte_ready = 0, byte_out and byte_valid hold stable. byte_valid never drops without a transfer.

Timing:
- The edge at which IDLE sees fifo_empty = 0 is edge E. fifo_rd_en is high in cycle E+1, and the first byte_valid is in cycle E+3.
- Minimum cost per word is 7 cycles (IDLE, REQ, WAIT, 4 × SEND). No prefetch is done.

Other rules:
- fifo_rd_en is never asserted outside REQ, so at most one read is outstanding.
- fifo_empty is ignored outside IDLE.
- busy is registered with the state: 0 in IDLE, 1 otherwise.
- words_done wraps from 2^CNT_W − 1 to 0.
- rd_err_cnt holds at 255.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, SEND = 2'd3
  - FIFO_DATA_W = 32
  - BYTE_W = 8
- A single module; no sub-module. The byte-select mux stays inline.

Test Plan:
1. Fifo preloaded with 32'h1234_5678, BYTE_ORDER = 0, byte_ready tied 1 -> one fifo_rd_en pulse; bytes 8'h78, 8'h56, 8'h34, 8'h12 on consecutive cycles starting 3 cycles after empty deasserts; words_done = 1, busy returns to 0.
2. Same word with BYTE_ORDER = 1 -> bytes 8'h12, 8'h34, 8'h56, 8'h78.
3. byte_ready = 0 for 5 cycles during byte 1 of 32'haaaa_eeee -> byte_out holds 8'hee with byte_valid = 1; on release, bytes continue 8'hee, 8'haa, 8'haa, with no duplicate or skipped byte.
4. Eight words written back to back (fifo full, including 32'h0230_0000 … 32'h5234_2345) -> eight separate rd_en pulses, 32 bytes in fifo order, words_done = 8, fifo ends empty, no rd_err seen.
5. Model forces fifo_empty = 0 with an empty fifo so the read returns fifo_rd_err = 1 -> no byte_valid; rd_err_cnt = 1; state returns to IDLE. Repeated 300 times -> rd_err_cnt stays at 255.
6. reset_n pulsed low during byte 2 of 32'hcccc_cccc -> byte_valid, fifo_rd_en, busy, words_done and rd_err_cnt go to 0 immediately, without waiting for a clock edge. After release with an empty fifo: no output activity.
